// File: rtl/detector_sequencia_pkg.sv
// Shared defaults, width helper and the per-cycle operation decode for the
// sequence detector.
package detector_sequencia_pkg;

  localparam int W_DEF     = 8;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // Bits needed to encode 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_CFG,
    OP_DATA
  } op_t;

endpackage

// File: rtl/detector_padrao_mem.sv
// Pattern register file: one write port plus two combinational read ports
// (current position and first word, used for restart decisions).
module detector_padrao_mem
  import detector_sequencia_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = width_of(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata,
  output logic [W-1:0]  rdata0
);

  logic [W-1:0] pat [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) pat[i] <= '0;
    end else if (we) begin
      pat[waddr] <= wdata;
    end
  end

  assign rdata  = pat[raddr];
  assign rdata0 = pat[0];

endmodule

// File: rtl/detector_sequencia.sv
// Streaming pattern detector: tracks how many consecutive pattern words have
// been seen, pulses match on completion and keeps a saturating match count.
//
// op        | meaning
// OP_HOLD   | no valid word: hold progress, drop match
// OP_CLEAR  | zero progress and match count, pattern kept
// OP_CFG    | pattern word written, progress restarts
// OP_DATA   | compare in_data against pattern word at current progress
module detector_sequencia
  import detector_sequencia_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int OVERLAP = 1,
  localparam int AW     = width_of(DEPTH),
  localparam int EW     = width_of(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [W-1:0]     cfg_data,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic [EW-1:0]    estado,
  output logic             match,
  output logic [CNT_W-1:0] match_count
);

  logic [W-1:0] pat_cur;
  logic [W-1:0] pat_first;
  logic         cfg_ok;
  logic         hit;
  logic         hit_first;
  logic         at_last;
  op_t          op;

  // Writes beyond the last pattern slot are treated as if cfg_we were low.
  assign cfg_ok = cfg_we && (int'(cfg_addr) < DEPTH);

  always_comb begin
    op = OP_HOLD;
    if (clear)         op = OP_CLEAR;
    else if (cfg_ok)   op = OP_CFG;
    else if (in_valid) op = OP_DATA;
  end

  detector_padrao_mem #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .we     (op == OP_CFG),
    .waddr  (cfg_addr),
    .wdata  (cfg_data),
    .raddr  (estado[AW-1:0]),
    .rdata  (pat_cur),
    .rdata0 (pat_first)
  );

  assign hit       = (in_data == pat_cur);
  assign hit_first = (in_data == pat_first);
  assign at_last   = (estado == EW'(DEPTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado      <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      case (op)
        OP_CLEAR: begin
          estado      <= '0;
          match       <= 1'b0;
          match_count <= '0;
        end
        OP_CFG: begin
          estado <= '0;
          match  <= 1'b0;
        end
        OP_DATA: begin
          if (hit && at_last) begin
            match <= 1'b1;
            if (match_count != '1) match_count <= match_count + CNT_W'(1);
            // Only the completing word itself may seed the next match.
            estado <= ((OVERLAP != 0) && hit_first) ? EW'(1) : '0;
          end else if (hit) begin
            match  <= 1'b0;
            estado <= estado + EW'(1);
          end else begin
            match  <= 1'b0;
            estado <= hit_first ? EW'(1) : '0;
          end
        end
        default: match <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_detector_sequencia.sv
// Directed and random-alphabet bench for detector_sequencia: three instances
// (overlap, no overlap, 2-bit counter) checked every cycle against a model.
module tb_detector_sequencia;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       in_valid;
  logic [7:0] in_data;

  logic [2:0] est_a, est_b, est_c;
  logic       m_a, m_b, m_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  int m_pat [4];
  int m_est [3];
  int m_cnt [3];
  int m_mat [3];
  int ov    [3] = '{1, 0, 1};
  int cmax  [3] = '{255, 255, 3};

  always #5 clk = ~clk;

  detector_sequencia #(.OVERLAP(1)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .in_valid(in_valid), .in_data(in_data),
    .estado(est_a), .match(m_a), .match_count(cnt_a));

  detector_sequencia #(.OVERLAP(0)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .in_valid(in_valid), .in_data(in_data),
    .estado(est_b), .match(m_b), .match_count(cnt_b));

  detector_sequencia #(.OVERLAP(1), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .clear(clear), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .in_valid(in_valid), .in_data(in_data),
    .estado(est_c), .match(m_c), .match_count(cnt_c));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pat[i] = 0;
    for (int i = 0; i < 3; i++) begin
      m_est[i] = 0; m_cnt[i] = 0; m_mat[i] = 0;
    end
  endtask

  // Applies the rules for one clock edge, using the inputs present at that edge.
  task automatic model_update();
    if (clear) begin
      for (int i = 0; i < 3; i++) begin
        m_est[i] = 0; m_cnt[i] = 0; m_mat[i] = 0;
      end
    end else if (cfg_we) begin
      m_pat[int'(cfg_addr)] = int'(cfg_data);
      for (int i = 0; i < 3; i++) begin
        m_est[i] = 0; m_mat[i] = 0;
      end
    end else if (in_valid) begin
      for (int i = 0; i < 3; i++) begin
        int d;
        d = int'(in_data);
        m_mat[i] = 0;
        if (d == m_pat[m_est[i]] && m_est[i] == 3) begin
          m_mat[i] = 1;
          if (m_cnt[i] < cmax[i]) m_cnt[i]++;
          m_est[i] = (ov[i] == 1 && d == m_pat[0]) ? 1 : 0;
        end else if (d == m_pat[m_est[i]]) begin
          m_est[i]++;
        end else begin
          m_est[i] = (d == m_pat[0]) ? 1 : 0;
        end
      end
    end else begin
      for (int i = 0; i < 3; i++) m_mat[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("est_a", int'(est_a), m_est[0]);
      chk("est_b", int'(est_b), m_est[1]);
      chk("est_c", int'(est_c), m_est[2]);
      chk("match_a", int'(m_a), m_mat[0]);
      chk("match_b", int'(m_b), m_mat[1]);
      chk("match_c", int'(m_c), m_mat[2]);
      chk("cnt_a", int'(cnt_a), m_cnt[0]);
      chk("cnt_b", int'(cnt_b), m_cnt[1]);
      chk("cnt_c", int'(cnt_c), m_cnt[2]);
    end
  end

  task automatic step(input bit v, input logic [7:0] d, input bit clr,
                      input bit we, input logic [1:0] a, input logic [7:0] wd);
    in_valid = v; in_data = d; clear = clr; cfg_we = we; cfg_addr = a; cfg_data = wd;
    @(posedge clk);
    model_update();
    #1;
    in_valid = 1'b0; clear = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic word(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic word_chk(input string name, input logic [7:0] d, input int exp_est);
    word(d);
    chk(name, int'(est_a), exp_est);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic do_clear();
    step(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic prog(input logic [7:0] p0, input logic [7:0] p1,
                      input logic [7:0] p2, input logic [7:0] p3);
    step(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, p0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 2'd1, p1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 2'd2, p2);
    step(1'b0, 8'h00, 1'b0, 1'b1, 2'd3, p3);
  endtask

  initial begin
    logic [7:0] alpha [4];
    clear = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_est", int'(est_a), 0);
    chk("reset_cnt", int'(cnt_a), 0);
    reset = 1'b1;

    prog(8'hD8, 8'hEB, 8'hCF, 8'hA8);

    // Basic match
    word_chk("basic_1", 8'hD8, 1);
    word_chk("basic_2", 8'hEB, 2);
    word_chk("basic_3", 8'hCF, 3);
    word_chk("basic_4", 8'hA8, 0);
    chk("basic_match", int'(m_a), 1);
    chk("basic_cnt", int'(cnt_a), 1);
    idle();
    chk("basic_pulse_end", int'(m_a), 0);
    chk("basic_cnt_hold", int'(cnt_a), 1);

    // Mismatch restart
    word_chk("restart_1", 8'hD8, 1);
    word_chk("restart_2", 8'hEB, 2);
    word_chk("restart_3", 8'hD8, 1);
    chk("restart_nomatch", int'(m_a), 0);
    word_chk("restart_4", 8'hEB, 2);
    word_chk("restart_5", 8'hCF, 3);
    word_chk("restart_6", 8'hA8, 0);
    chk("restart_cnt", int'(cnt_a), 2);

    // Bubbles, then clear
    word(8'hD8); idle();
    word(8'hEB); idle();
    chk("gap_hold", int'(est_a), 2);
    word(8'hCF); idle();
    word(8'hA8);
    chk("gap_match", int'(m_a), 1);
    chk("gap_cnt", int'(cnt_a), 3);
    idle();
    do_clear();
    chk("clear_est", int'(est_a), 0);
    chk("clear_cnt", int'(cnt_a), 0);

    // clear outranks a simultaneous pattern write
    step(1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 8'h00);
    word(8'hD8); word(8'hEB); word(8'hCF); word(8'hA8);
    chk("clear_beats_cfg", int'(cnt_a), 1);

    // Reset mid-sequence
    word(8'hD8);
    word_chk("pre_reset", 8'hEB, 2);
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_est", int'(est_a), 0);
    chk("async_cnt", int'(cnt_a), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    word_chk("pat_zeroed", 8'h00, 1);

    prog(8'hD8, 8'hEB, 8'hCF, 8'hA8);
    word(8'hD8);
    word(8'hEB);
    step(1'b1, 8'hCF, 1'b0, 1'b1, 2'd3, 8'hA8);
    chk("cfg_drop_est", int'(est_a), 0);
    word_chk("cfg_drop_next", 8'hA8, 0);
    chk("cfg_drop_nomatch", int'(m_a), 0);

    // Overlap
    prog(8'hAA, 8'hBB, 8'hAA, 8'hAA);
    do_clear();
    word(8'hAA); word(8'hBB); word(8'hAA); word(8'hAA);
    word(8'hBB); word(8'hAA); word(8'hAA);
    chk("overlap_on", int'(cnt_a), 2);
    chk("overlap_off", int'(cnt_b), 1);
    do_clear();
    word(8'hAA); word(8'hBB); word(8'hAA); word(8'hAA);
    for (int k = 0; k < 4; k++) begin
      word(8'hBB); word(8'hAA); word(8'hAA);
    end
    chk("sat_cnt2", int'(cnt_c), 3);
    chk("nosat_cnt8", int'(cnt_a), 5);
    chk("overlap_off_cnt", int'(cnt_b), 3);

    // Random words over the pattern alphabet
    prog(8'hD8, 8'hEB, 8'hCF, 8'hA8);
    alpha[0] = 8'hD8; alpha[1] = 8'hEB; alpha[2] = 8'hCF; alpha[3] = 8'hA8;
    for (int k = 0; k < 400; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2)
        step(1'b1, alpha[$urandom_range(0, 3)], 1'b1, 1'b0, 2'd0, 8'h00);
      else if (r < 4)
        step(1'b1, alpha[$urandom_range(0, 3)], 1'b0, 1'b1,
             2'($urandom_range(0, 3)), alpha[$urandom_range(0, 3)]);
      else
        step(r < 84, alpha[$urandom_range(0, 3)], 1'b0, 1'b0, 2'd0, 8'h00);
    end
    idle();

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/detector_sequencia.md
DETECTOR_SEQUENCIA -- requirements
Module: detector_sequencia

Interface
REQ-001 Parameter W, default 8: width of each input and pattern word.
REQ-002 Parameter DEPTH, default 4, range 2..16: number of words in the programmed pattern.
REQ-003 Parameter CNT_W, default 8: width of the match counter.
REQ-004 Parameter OVERLAP, default 1: selects the restart rule after a full match (1 = re-check last word, 0 = plain restart).
REQ-005 clk  in  1  single clock; all state updates occur on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 clear  in  1  synchronous clear of estado and match_count.
REQ-008 cfg_we  in  1  pattern-word write strobe.
REQ-009 cfg_addr  in  clog2(DEPTH)  index of the pattern word to write.
REQ-010 cfg_data  in  W  pattern word to write.
REQ-011 in_valid  in  1  qualifies in_data for the current cycle.
REQ-012 in_data  in  W  stream word under test.
REQ-013 estado  out  clog2(DEPTH+1)  count of consecutive pattern words currently matched (0..DEPTH-1).
REQ-014 match  out  1  one-cycle pulse when the full pattern completes.
REQ-015 match_count  out  CNT_W  saturating count of completed matches.

Function
REQ-016 The block SHALL hold pat[0..DEPTH-1] in registers; a cfg_we write to cfg_addr SHALL be visible from the next cycle.
REQ-017 A cfg_addr value >= DEPTH SHALL be ignored.
REQ-018 Per-cycle priority SHALL be: reset > clear > cfg_we > in_valid.
REQ-019 clear SHALL set estado=0, match_count=0 and match=0 next cycle, leaving pat unchanged.
REQ-020 Any accepted cfg_we SHALL force estado=0 and match=0 next cycle; a simultaneous in_valid word SHALL be discarded.
REQ-021 With in_valid=0, estado and match_count SHALL hold and match SHALL be 0 next cycle.
REQ-022 With in_valid=1 and in_data==pat[estado] and estado<DEPTH-1, estado SHALL become estado+1.
REQ-023 With in_valid=1 and in_data==pat[DEPTH-1] and estado==DEPTH-1, match SHALL be 1 in the next cycle (registered, latency 1), and match_count SHALL increment unless it is all-ones, where it saturates.
REQ-024 In the REQ-023 case, estado SHALL become 1 if OVERLAP=1 and in_data==pat[0]; otherwise it SHALL become 0.
REQ-025 On a mismatch (in_valid=1, in_data!=pat[estado]), estado SHALL become 1 if in_data==pat[0], else 0; this is a simple restart, with no general failure function.
REQ-026 match SHALL never be high for two consecutive cycles unless two matches complete back-to-back (possible only when DEPTH words arrive continuously after an overlap restart).

Reset
REQ-027 While reset=0, asynchronously: estado=0, match=0, match_count=0, all pat words=0.
REQ-028 Reset asserted mid-sequence SHALL discard partial progress; after release, matching SHALL resume from estado=0.

Structure
REQ-029 A shared package SHALL hold the default W/DEPTH/CNT_W values and the clog2-based width helper.
REQ-030 The pattern register file SHALL be a sub-module named detector_padrao_mem (write port plus indexed read port for pat[estado] and pat[0]); the FSM and counter SHALL be in the top level.

Verification
All scenarios use W=8, DEPTH=4, pattern D8,EB,CF,A8 unless stated otherwise.
REQ-031 Basic match: stream D8,EB,CF,A8 with in_valid=1 -> estado 1,2,3,0; match pulses once, one cycle after A8; match_count=1.
REQ-032 Mismatch restart: stream D8,EB,D8,EB,CF,A8 -> estado 1,2,1,2,3,0; exactly one match.
REQ-033 Gaps and clear: the REQ-031 stream with in_valid=0 bubbles between words -> same result; a subsequent clear=1 -> estado=0 and match_count=0.
REQ-034 Overlap: pattern AA,BB,AA,AA with stream AA,BB,AA,AA,BB,AA,AA -> OVERLAP=1 gives 2 matches and OVERLAP=0 gives 1; CNT_W=2 with 5 matches -> match_count saturates at 3.
REQ-035 Reset and config: reset=0 asserted after D8,EB -> immediate zeros, pattern cleared; after reprogramming, cfg_we issued mid-sequence together with in_valid -> estado=0 and the input word is dropped.
